icache_assoc: RTL and testbench
===============================

# icache_assoc

Parametrised set-associative instruction cache between the datapath fetch port and the memory-controller instruction port. It generalises the direct-mapped single-word icache to configurable sets, ways and multi-word blocks. It adds per-set round-robin replacement, a whole-cache flush, and saturating hit/miss counters. Misses fill a full block word-by-word over the existing `iREN`/`iwait`/`iload` handshake.

## Interface
- `SETS`, 8: number of sets; power of 2, ≥2.
- `WAYS`, 2: associativity; power of 2, 1–4.
- `BLOCK_WORDS`, 2: 32-bit words per block; power of 2, 1–8.
- `CLK` in 1: single clock; all state on rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `imemREN` in 1: datapath fetch request.
- `imemaddr` in 32: fetch byte address, word-aligned.
- `dmemREN`, `dmemWEN` in 1 each: datapath data access in progress; suppress hit and miss start.
- `iflush` in 1: invalidate whole cache.
- `ihit` out 1: fetch satisfied this cycle.
- `imemload` out 32: instruction word; valid when `ihit`.
- `iREN` out 1: memory read request.
- `iaddr` out 32: memory read address.
- `iwait` in 1: memory not ready; `iload` valid when low with `iREN` high.
- `iload` in 32: memory read data.
- `hit_count`, `miss_count` out 32: performance counters.

## Operation
- Address split: `[1:0]` byte (ignored); `[bo+1:2]` word offset, where `bo = log2(BLOCK_WORDS)`; next `log2(SETS)` bits are the index; remaining upper bits are the tag.
- Storage per set and way: valid bit, tag, `BLOCK_WORDS` data words. Per set: a round-robin pointer of `log2(WAYS)` bits.
- A lookup hit requires all of: `valid`, tag match in any way, `imemREN`, `!(dmemREN|dmemWEN)`, and state LOOKUP.
- `ihit` is the lookup hit. `imemload` is the matching way's word at the word offset when `ihit`, else 0.
- FSM states:
  - LOOKUP: on `imemREN & !hit & !(dmemREN|dmemWEN) & !iflush`, latch tag and index into the fill register, clear the word counter, and go to FILL.
  - FILL: `iREN=1`; `iaddr = {fill_tag, fill_idx, word_cnt, 2'b00}`. Each cycle with `iwait=0`, write `iload` into `victim[word_cnt]` and increment `word_cnt`. After the last word, set `valid`/tag of the victim, advance that set's pointer modulo `WAYS`, and go to LOOKUP.
- Victim selection at FILL entry: lowest-numbered invalid way; if none, the set's round-robin pointer. The victim's valid bit is cleared at FILL entry.
- Outside FILL, `iREN=0` and `iaddr=0`.
- A change of `imemaddr` during FILL does not abort the fill; the latched block completes.
- `iflush`: clears all valid bits and all round-robin pointers next edge. In FILL it aborts the fill (partial block stays invalid) and returns to LOOKUP. Flush has priority over a miss start and over fill completion in the same cycle.
- Counters: `hit_count` +1 per cycle `ihit=1`; `miss_count` +1 per LOOKUP→FILL transition. Both saturate at `32'hFFFF_FFFF`. Flush does not clear them.

## Timing
- Reset (async on `RST` high): state LOOKUP, all valid 0, pointers 0, counters 0. Hence `ihit=0`, `imemload=0`, `iREN=0`, `iaddr=0`. Data/tag arrays are not reset.
- Hit: combinational, same cycle as the request; zero added latency.
- Miss with the request held:
  - Cycle 0: detect miss; `ihit=0`.
  - Cycles 1..: FILL, taking `BLOCK_WORDS × (wait cycles + 1)` cycles.
  - The cycle after the last word: LOOKUP with `ihit=1`.
  - Minimum miss penalty is `BLOCK_WORDS + 1` cycles.
- `iREN`/`iaddr` are stable while `iwait=1`. Data is accepted only on `iwait=0`.
- `RST` mid-fill drops everything immediately; outputs return to reset values.

## Test plan
Configuration: `SETS=8`, `WAYS=2`, `BLOCK_WORDS=2`, memory `iwait` high 1 cycle per word.
- Cold miss at `0x40`: expect `iaddr` `0x40` then `0x44`, `iREN` high 4 cycles, `ihit=1` with `iload` word 0 on the next cycle, `miss_count=1`. Then fetch `0x44`: same-cycle hit, `hit_count=2`.
- Same-set conflict, fetching in order:
  - `0x040`, `0x440`: fill ways 0 and 1.
  - `0x840`: evicts way 0.
  - `0x440`: hits.
  - `0x040`: misses and evicts way 1.
  - Final `miss_count=4`.
- Hit suppression: valid block at `0x40`, `imemREN=1` with `dmemWEN=1` → `ihit=0`, `iREN=0`, no FILL. Drop `dmemWEN` → `ihit=1` the same cycle.
- Flush mid-fill: miss at `0x80`, assert `iflush` after word 0 → next cycle LOOKUP, `iREN=0`. Refetch `0x80` misses again; previously valid `0x40` now misses.
- Fetch address changes to `0x100` during the `0x80` fill: both words of `0x80` are still fetched, then `0x100` misses (`miss_count` +2 total).
- Assert `RST` during FILL: `iREN`, `iaddr`, `ihit`, and counters are 0 immediately. A subsequent fetch of any address misses.

Source files
------------

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache sitting between the
// datapath fetch port and the memory-controller instruction port.
//
// Ports:
//   CLK, RST                : clock, asynchronous active-high reset
//   imemREN, imemaddr       : fetch request and word-aligned byte address
//   dmemREN, dmemWEN        : data access in progress (holds off hit/miss)
//   iflush                  : invalidate the whole cache
//   ihit, imemload          : fetch satisfied this cycle, instruction word
//   iREN, iaddr             : memory read request/address (only in FILL)
//   iwait, iload            : memory not-ready flag and read data
//   hit_count, miss_count   : saturating performance counters
module icache_assoc #(
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int BO = $clog2(BLOCK_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - BO - IW;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CW = (BO > 0) ? BO : 1;
  localparam logic [31:0]   OFF_MASK  = 32'(BLOCK_WORDS * 4 - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_WORDS - 1);

  typedef enum logic {S_LOOKUP = 1'b0, S_FILL = 1'b1} state_t;
  state_t state_q, state_d;

  // Storage: data and tags are plain arrays (not reset); valid and
  // round-robin pointers are reset flops.
  logic [31:0]     data_mem [SETS][WAYS][BLOCK_WORDS];
  logic [TW-1:0]   tag_mem  [SETS][WAYS];
  logic [WAYS-1:0] valid_q  [SETS];
  logic [WAYS-1:0] valid_d  [SETS];
  logic [WW-1:0]   ptr_q    [SETS];
  logic [WW-1:0]   ptr_d    [SETS];

  logic [31:0]   fill_addr_q, fill_addr_d;   // block base address being filled
  logic [WW-1:0] victim_q, victim_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [31:0]   hit_count_q, hit_count_d;
  logic [31:0]   miss_count_q, miss_count_d;

  // Request address fields
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [CW-1:0] req_off;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          unused_addr_bits;

  assign req_idx          = imemaddr[BO+2 +: IW];
  assign req_tag          = imemaddr[31 -: TW];
  assign fill_idx         = fill_addr_q[BO+2 +: IW];
  assign fill_tag         = fill_addr_q[31 -: TW];
  assign unused_addr_bits = ^imemaddr[1:0];

  generate
    if (BO > 0) begin : g_off
      assign req_off = imemaddr[2 +: CW];
    end else begin : g_no_off
      assign req_off = '0;
    end
  endgenerate

  // Per-way tag compare for the requested set
  logic [WAYS-1:0] way_match;
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
      assign way_match[gi] = valid_q[req_idx][gi] && (tag_mem[req_idx][gi] == req_tag);
    end
  endgenerate

  logic [WW-1:0] hit_way;
  logic [WW-1:0] victim_sel;

  // Descending scans leave the lowest-numbered qualifying way selected.
  always_comb begin
    hit_way    = '0;
    victim_sel = ptr_q[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_match[w]) hit_way = WW'(w);
      if (!valid_q[req_idx][w]) victim_sel = WW'(w);
    end
  end

  logic dmem_busy, lookup_hit, miss_start, word_take, fill_last, fill_done;

  assign dmem_busy  = dmemREN | dmemWEN;
  assign lookup_hit = (state_q == S_LOOKUP) && imemREN && !dmem_busy && (|way_match);
  assign miss_start = (state_q == S_LOOKUP) && imemREN && !dmem_busy && !(|way_match) && !iflush;
  assign word_take  = (state_q == S_FILL) && !iwait;
  assign fill_last  = word_take && (word_cnt_q == LAST_WORD);
  // Flush wins over completion: an aborted block never becomes valid.
  assign fill_done  = fill_last && !iflush;

  // FSM: state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_LOOKUP;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOOKUP: if (miss_start) state_d = S_FILL;
      S_FILL:   if (iflush || fill_last) state_d = S_LOOKUP;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ihit     = lookup_hit;
    imemload = lookup_hit ? data_mem[req_idx][hit_way][req_off] : 32'd0;
    iREN     = (state_q == S_FILL);
    iaddr    = (state_q == S_FILL) ? (fill_addr_q | (32'(word_cnt_q) << 2)) : 32'd0;
  end

  // Datapath next-state
  always_comb begin
    valid_d      = valid_q;
    ptr_d        = ptr_q;
    fill_addr_d  = fill_addr_q;
    victim_d     = victim_q;
    word_cnt_d   = word_cnt_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;

    if (miss_start) begin
      fill_addr_d = imemaddr & ~OFF_MASK;
      victim_d    = victim_sel;
      word_cnt_d  = '0;
      valid_d[req_idx][victim_sel] = 1'b0;
    end
    if (word_take) word_cnt_d = word_cnt_q + 1'b1;
    if (fill_done) begin
      valid_d[fill_idx][victim_q] = 1'b1;
      ptr_d[fill_idx] = (WAYS > 1) ? ptr_q[fill_idx] + 1'b1 : '0;
    end
    if (iflush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_d[s] = '0;
        ptr_d[s]   = '0;
      end
    end

    if (lookup_hit && (hit_count_q != 32'hFFFF_FFFF)) hit_count_d = hit_count_q + 32'd1;
    if (miss_start && (miss_count_q != 32'hFFFF_FFFF)) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
      fill_addr_q  <= '0;
      victim_q     <= '0;
      word_cnt_q   <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ptr_q        <= ptr_d;
      fill_addr_q  <= fill_addr_d;
      victim_q     <= victim_d;
      word_cnt_q   <= word_cnt_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Data/tag arrays: written during fill, never reset.
  always_ff @(posedge CLK) begin
    if (word_take) data_mem[fill_idx][victim_q][word_cnt_q] <= iload;
    if (fill_done) tag_mem[fill_idx][victim_q] <= fill_tag;
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_assoc.sv
module tb_icache_assoc;

  localparam int SETS        = 8;
  localparam int WAYS        = 2;
  localparam int BLOCK_WORDS = 2;
  localparam int BO          = $clog2(BLOCK_WORDS);

  logic        CLK, RST;
  logic        imemREN, dmemREN, dmemWEN, iflush, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr, hit_count, miss_count;

  icache_assoc #(.SETS(SETS), .WAYS(WAYS), .BLOCK_WORDS(BLOCK_WORDS)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .iflush(iflush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backing memory contents: a fixed function of the word address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- reference model (block-level) ----------------
  bit          mv   [SETS][WAYS];
  logic [31:0] mt   [SETS][WAYS];   // block base address held in each way
  int          mptr [SETS];
  int          m_hits, m_miss;

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> (2 + BO)) % SETS);
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a & ~32'(BLOCK_WORDS * 4 - 1);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int s = set_of(a);
    for (int w = 0; w < WAYS; w++)
      if (mv[s][w] && mt[s][w] == base_of(a)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_install(input logic [31:0] a);
    int s = set_of(a);
    int v = -1;
    for (int w = 0; w < WAYS; w++)
      if (!mv[s][w] && v < 0) v = w;
    if (v < 0) v = mptr[s];
    mv[s][v] = 1'b1;
    mt[s][v] = base_of(a);
    mptr[s]  = (mptr[s] + 1) % WAYS;
  endtask

  task automatic m_clear();
    for (int s = 0; s < SETS; s++) begin
      mptr[s] = 0;
      for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
    end
  endtask

  // ---------------- memory responder ----------------
  bit rand_wait = 1'b0;
  bit phase     = 1'b1;

  initial begin
    iwait = 1'b1;
    iload = '0;
    forever begin
      @(negedge CLK);
      if (iREN) begin
        iwait = rand_wait ? 1'($urandom_range(0, 1)) : phase;
        phase = ~phase;
      end else begin
        iwait = 1'($urandom_range(0, 1));
        phase = 1'b1;
      end
      iload = (iREN && !iwait) ? memfn(iaddr) : $urandom;
    end
  end

  // ---------------- transaction tasks ----------------
  // Called at the sample point of the first FILL cycle; returns at the
  // sample point of the first cycle after FILL.
  task automatic run_fill(input logic [31:0] base, output int cyc);
    int k = 0;
    cyc = 0;
    while (iREN && cyc < 200) begin
      cyc++;
      if (!iwait) begin
        chk("fill_addr", iaddr, base + 32'(4 * k));
        k++;
      end
      @(negedge CLK);
      #1;
    end
    chk("fill_words", 32'(k), 32'(BLOCK_WORDS));
    chk("fill_done", {31'd0, iREN}, 32'd0);
  endtask

  // stall: 0 none, 1 dmemWEN, 2 dmemREN held during the first cycle
  task automatic fetch(input logic [31:0] a, input int stall, output int cyc);
    bit exp_hit;
    cyc      = 0;
    imemREN  = 1'b1;
    imemaddr = a;
    iflush   = 1'b0;
    if (stall != 0) begin
      dmemWEN = (stall == 1);
      dmemREN = (stall == 2);
      #1;
      chk("stall_ihit", {31'd0, ihit}, 32'd0);
      chk("stall_iren", {31'd0, iREN}, 32'd0);
      chk("stall_load", imemload, 32'd0);
      @(negedge CLK);
      #1;
      chk("stall_nofill", {31'd0, iREN}, 32'd0);
      dmemWEN = 1'b0;
      dmemREN = 1'b0;
    end
    #1;
    chk("hit_count", hit_count, 32'(m_hits));
    chk("miss_count", miss_count, 32'(m_miss));
    exp_hit = m_hit(a);
    chk("lookup_hit", {31'd0, ihit}, {31'd0, exp_hit});
    if (!exp_hit) begin
      chk("miss_iren_low", {31'd0, iREN}, 32'd0);
      m_miss++;
      @(negedge CLK);
      #1;
      run_fill(base_of(a), cyc);
      m_install(a);
      chk("post_fill_hit", {31'd0, ihit}, 32'd1);
    end
    chk("imemload", imemload, memfn(a));
    m_hits++;
    $display("fetch %h stall=%0d hit=%0d fill_cycles=%0d", a, stall, exp_hit, cyc);
    @(negedge CLK);
    imemREN = 1'b0;
  endtask

  task automatic do_flush();
    imemREN = 1'b0;
    iflush  = 1'b1;
    @(negedge CLK);
    iflush  = 1'b0;
    m_clear();
    $display("flush");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int w;
    logic [31:0] ra;

    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; dmemREN = 1'b0; dmemWEN = 1'b0; iflush = 1'b0;
    m_clear(); m_hits = 0; m_miss = 0;
    #1;
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_load", imemload, 32'd0);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Cold miss then same-block hit
    fetch(32'h40, 0, cyc);
    chk("cold_iren_cycles", 32'(cyc), 32'(2 * BLOCK_WORDS));
    #1 chk("cold_miss_count", miss_count, 32'd1);
    fetch(32'h44, 0, cyc);
    #1 chk("hit_count_two", hit_count, 32'd2);

    // Same-set conflict and round-robin eviction
    fetch(32'h040, 0, cyc);
    fetch(32'h440, 0, cyc);
    fetch(32'h840, 0, cyc);
    fetch(32'h440, 0, cyc);
    fetch(32'h040, 0, cyc);
    #1 chk("conflict_miss_count", miss_count, 32'd4);

    // Data-access suppression of a valid block
    fetch(32'h40, 1, cyc);
    fetch(32'h40, 2, cyc);

    // Flush in the middle of a fill
    imemREN = 1'b1; imemaddr = 32'h80;
    #1;
    chk("flush_start_hit", {31'd0, ihit}, {31'd0, m_hit(32'h80)});
    m_miss++;
    @(negedge CLK); #1;
    w = 0;
    while (!(iREN && !iwait) && w < 50) begin
      @(negedge CLK); #1;
      w++;
    end
    chk("flush_word0_addr", iaddr, 32'h80);
    @(negedge CLK);
    iflush = 1'b1; imemREN = 1'b0;
    @(negedge CLK);
    iflush = 1'b0;
    #1;
    chk("flush_iren", {31'd0, iREN}, 32'd0);
    chk("flush_iaddr", iaddr, 32'd0);
    chk("flush_ihit", {31'd0, ihit}, 32'd0);
    m_clear();
    $display("flush during fill of 00000080");
    @(negedge CLK);
    fetch(32'h80, 0, cyc);
    fetch(32'h40, 0, cyc);

    // Fetch address changes while a fill is under way
    do_flush();
    imemREN = 1'b1; imemaddr = 32'h80;
    #1;
    chk("addrchg_first_hit", {31'd0, ihit}, {31'd0, m_hit(32'h80)});
    m_miss++;
    @(negedge CLK);
    imemaddr = 32'h100;
    #1;
    run_fill(32'h80, cyc);
    m_install(32'h80);
    chk("addrchg_second_hit", {31'd0, ihit}, {31'd0, m_hit(32'h100)});
    m_miss++;
    @(negedge CLK); #1;
    run_fill(32'h100, cyc);
    m_install(32'h100);
    chk("addrchg_final_hit", {31'd0, ihit}, 32'd1);
    chk("addrchg_load", imemload, memfn(32'h100));
    m_hits++;
    $display("fetch 00000080 redirected to 00000100");
    @(negedge CLK);
    imemREN = 1'b0;
    #1 chk("addrchg_miss_count", miss_count, 32'(m_miss));
    @(negedge CLK);

    // Reset in the middle of a fill
    do_flush();
    imemREN = 1'b1; imemaddr = 32'h200;
    #1;
    chk("rstfill_hit", {31'd0, ihit}, {31'd0, m_hit(32'h200)});
    @(negedge CLK); #1;
    chk("rstfill_in_fill", {31'd0, iREN}, 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("rstfill_iren", {31'd0, iREN}, 32'd0);
    chk("rstfill_iaddr", iaddr, 32'd0);
    chk("rstfill_ihit", {31'd0, ihit}, 32'd0);
    chk("rstfill_hits", hit_count, 32'd0);
    chk("rstfill_miss", miss_count, 32'd0);
    m_clear(); m_hits = 0; m_miss = 0;
    $display("reset during fill of 00000200");
    @(negedge CLK);
    RST = 1'b0; imemREN = 1'b0;
    @(negedge CLK);
    fetch(32'h44, 0, cyc);

    // Randomised traffic against the model
    rand_wait = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int r;
      r  = int'($urandom_range(0, 15));
      ra = (32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 3)) << 3) |
           (32'($urandom_range(0, 1)) << 2);
      if (r == 0) do_flush();
      else fetch(ra, (r == 1) ? 1 : ((r == 2) ? 2 : 0), cyc);
    end

    #1;
    chk("final_hits", hit_count, 32'(m_hits));
    chk("final_miss", miss_count, 32'(m_miss));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
